// File: rtl/dmem_if_pkg.sv
// rtl/dmem_if_pkg.sv - funct3 size codes, FSM states and lane constants for dmem_if
package dmem_if_pkg;

  localparam logic [2:0] INST_BYTE        = 3'b000;
  localparam logic [2:0] INST_HALF_WORD   = 3'b001;
  localparam logic [2:0] INST_WORD        = 3'b010;
  localparam logic [2:0] INST_BYTE_U      = 3'b100;
  localparam logic [2:0] INST_HALF_WORD_U = 3'b101;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_REQ    = 2'd1,
    DMEM_WAIT_R = 2'd2,
    DMEM_RESP   = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte enables, misalign detect and lane shifts for a 4-lane bus
module dmem_lane_align
  import dmem_if_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_off_i,
  input  logic [1:0]            rd_off_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (funct3_i)
      INST_BYTE, INST_BYTE_U: be_o = 4'b0001 << addr_off_i;
      INST_HALF_WORD, INST_HALF_WORD_U: begin
        be_o       = 4'b0011 << addr_off_i;
        misalign_o = addr_off_i[0];
      end
      INST_WORD: begin
        be_o       = 4'b1111;
        misalign_o = |addr_off_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

  // Read data is returned with the addressed byte in [7:0]; extension is done upstream.
  assign wdata_o = wdata_i << (BYTE_WIDTH * int'(addr_off_i));
  assign rdata_o = rdata_i >> (BYTE_WIDTH * int'(rd_off_i));

endmodule

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - MEM-stage data-memory bus interface with req/gnt/rvalid handshake and timeout
module dmem_if
  import dmem_if_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wmem_en_i,
  input  logic                  rmem_en_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  hold_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [3:0]            bus_be_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dmem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;
  logic                  bus_err_q, bus_err_d;

  logic                  access;
  logic                  timeout;
  logic [3:0]            lane_be;
  logic                  lane_misalign;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] lane_rdata;

  assign access  = wmem_en_i | rmem_en_i;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  dmem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_align (
    .funct3_i  (funct3_i),
    .addr_off_i(mem_addr_i[1:0]),
    .rd_off_i  (off_q),
    .wdata_i   (mem_data_i),
    .rdata_i   (bus_rdata_i),
    .be_o      (lane_be),
    .misalign_o(lane_misalign),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    off_d      = off_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_o    = 1'b0;
    bus_req_o  = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        stall_o = access;
        if (access && lane_misalign) begin
          misalign_d = 1'b1;
          rdata_d    = '0;
          state_d    = DMEM_RESP;
        end else if (access) begin
          addr_d  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
          off_d   = mem_addr_i[1:0];
          be_d    = lane_be;
          wdata_d = lane_wdata;
          we_d    = wmem_en_i;
          cnt_d   = '0;
          state_d = DMEM_REQ;
        end
      end
      DMEM_REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // A grant on the last allowed cycle still completes the access.
        if (bus_gnt_i) begin
          state_d = we_q ? DMEM_RESP : DMEM_WAIT_R;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = DMEM_RESP;
        end
      end
      DMEM_WAIT_R: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bus_rvalid_i) begin
          rdata_d = lane_rdata;
          state_d = DMEM_RESP;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = DMEM_RESP;
        end
      end
      DMEM_RESP: begin
        if (!hold_i) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= DMEM_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_if.sv
// tb/tb_dmem_if.sv - directed scoreboard bench for dmem_if
module tb_dmem_if;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wmem_en_i, rmem_en_i, hold_i;
  logic [2:0]  funct3_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [31:0] rdata_o;
  logic        stall_o, misalign_o, bus_err_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wmem_en_i(wmem_en_i), .rmem_en_i(rmem_en_i), .funct3_i(funct3_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .hold_i(hold_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int gnt_dly,
                        input logic [31:0] rd, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic mis, input int hold_n);
    int stalls = 0, reqs = 0, unstable = 0, exp_stalls, exp_reqs;
    logic rv_pend = 1'b0, done = 1'b0, to;
    logic [31:0] ca = '0, cw = '0, e;
    logic [3:0] cb = '0;
    logic cwe = 1'b0;
    to = !mis && (gnt_dly >= TIMEOUT);
    e = (we && !mis && !to) ? last_rd : exp_rd;
    exp_q.push_back(e);
    last_rd = e;
    exp_stalls = mis ? 1 : to ? 1 + TIMEOUT : (we ? 2 + gnt_dly : 3 + gnt_dly);
    exp_reqs   = mis ? 0 : to ? TIMEOUT : gnt_dly + 1;
    wmem_en_i = we; rmem_en_i = !we; funct3_i = f3; mem_addr_i = addr; mem_data_i = wd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_o) begin done = 1'b1; break; end
      stalls++;
      if (bus_req_o) begin
        if (reqs == 0) begin
          ca = bus_addr_o; cb = bus_be_o; cw = bus_wdata_o; cwe = bus_we_o;
        end else if (ca !== bus_addr_o || cb !== bus_be_o || cw !== bus_wdata_o || cwe !== bus_we_o) begin
          unstable++;
        end
        reqs++;
      end
      bus_gnt_i    = bus_req_o && (reqs > gnt_dly);
      bus_rvalid_i = rv_pend;
      bus_rdata_i  = rd;
      rv_pend      = rv_pend | (bus_gnt_i && !we);
      @(negedge clk);
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    chk({tag, " completes"}, 32'(done), 32'd1);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, " req cycles"}, 32'(reqs), 32'(exp_reqs));
    chk({tag, " rdata"}, rdata_o, exp_q.pop_front());
    chk({tag, " misalign"}, 32'(misalign_o), 32'(mis));
    chk({tag, " bus_err"}, 32'(bus_err_o), 32'(to));
    chk({tag, " req low in resp"}, 32'(bus_req_o), 32'd0);
    if (exp_reqs > 0) begin
      chk({tag, " bus_addr"}, ca, {addr[31:2], 2'b00});
      chk({tag, " bus_we"}, 32'(cwe), 32'(we));
      chk({tag, " bus_be"}, 32'(cb), 32'(exp_be));
      chk({tag, " stable"}, 32'(unstable), 32'd0);
      if (we) chk({tag, " bus_wdata"}, cw, exp_wd);
    end
    for (int h = 0; h < hold_n; h++) begin
      hold_i = 1'b1; wmem_en_i = 1'b0; rmem_en_i = 1'b1; funct3_i = 3'b010; mem_addr_i = 32'h300;
      @(negedge clk); #1;
      chk({tag, " hold stall"}, 32'(stall_o), 32'd0);
      chk({tag, " hold req"}, 32'(bus_req_o), 32'd0);
      chk({tag, " hold rdata"}, rdata_o, e);
    end
    hold_i = 1'b0; wmem_en_i = 1'b0; rmem_en_i = 1'b0;
    @(negedge clk); #1;
    chk({tag, " idle stall"}, 32'(stall_o), 32'd0);
    chk({tag, " pulse end"}, {30'd0, misalign_o, bus_err_o}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wmem_en_i = 1'b0; rmem_en_i = 1'b0; hold_i = 1'b0;
    funct3_i = 3'b000; mem_addr_i = '0; mem_data_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", {rdata_o | bus_addr_o | bus_wdata_o}, 32'd0);
    chk("reset ctrl", {23'd0, stall_o, misalign_o, bus_err_o, bus_req_o, bus_we_o, bus_be_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    access("lw 0x100", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 0);
    access("lb 0x103", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF0000, 32'h00000080, 4'b1000, 32'h0, 1'b0, 0);
    access("sh 0x102", 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 2, 32'h0, 32'h0, 4'b1100, 32'hABCD0000, 1'b0, 0);
    access("sw 0x101", 1'b1, 3'b010, 32'h101, 32'h11223344, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1, 0);
    access("lhu 0x102", 1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h12345678, 32'h00001234, 4'b1100, 32'h0, 1'b0, 2);
    access("sb 0x001", 1'b1, 3'b000, 32'h001, 32'h000000A5, 0, 32'h0, 32'h0, 4'b0010, 32'h0000A500, 1'b0, 0);
    access("bad funct3", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'hFFFFFFFF, 32'h0, 4'b0000, 32'h0, 1'b1, 0);
    access("lw 0x104", 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h0BADF00D, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 0);
    access("lw no gnt", 1'b0, 3'b010, 32'h100, 32'h0, 1000, 32'h0, 32'h0, 4'b1111, 32'h0, 1'b0, 0);

    rmem_en_i = 1'b1; funct3_i = 3'b010; mem_addr_i = 32'h100; bus_gnt_i = 1'b1;
    @(negedge clk); #1;
    chk("rst seq req", 32'(bus_req_o), 32'd1);
    @(negedge clk); #1;
    bus_gnt_i = 1'b0;
    chk("rst seq wait_r", {30'd0, stall_o, bus_req_o}, 32'b10);
    rst_n = 1'b0; rmem_en_i = 1'b0;
    @(negedge clk); #1;
    chk("mid reset data", {rdata_o | bus_addr_o | bus_wdata_o}, 32'd0);
    chk("mid reset ctrl", {23'd0, stall_o, misalign_o, bus_err_o, bus_req_o, bus_we_o, bus_be_o}, 32'd0);
    rst_n = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55555555;
    @(negedge clk); #1;
    bus_rvalid_i = 1'b0;
    chk("stale rvalid stall", 32'(stall_o), 32'd0);
    chk("stale rvalid rdata", rdata_o, 32'd0);
    last_rd = '0;
    access("lw after reset", 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_if.md
Name: dmem_if

Overview:
- Data-memory bus interface directly downstream of the MEM stage.
- Consumes the MEM stage's wmem_en/rmem_en/mem_addr/mem_data outputs plus funct3.
- Runs a req/gnt/rvalid transaction to data RAM and stalls the pipeline until the access completes.
- Returns lane-aligned read data (byte 0 in bits [7:0]) to the MEM stage's mem_data_i for sign/zero extension.

Parameters:
ADDR_WIDTH, 32, data address width (matches `MemAddrBus)
DATA_WIDTH, 32, bus data width (matches `WordBus); fixed 4 byte lanes
TIMEOUT_CYCLES, 15, max cycles waiting in REQ or WAIT_R before bus error

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
wmem_en_i  input  1  store request from MEM stage
rmem_en_i  input  1  load request from MEM stage
funct3_i  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_addr_i  input  ADDR_WIDTH  byte address
mem_data_i  input  DATA_WIDTH  store data, low-justified
hold_i  input  1  downstream not advancing this cycle
rdata_o  output  DATA_WIDTH  load data, shifted so the addressed byte is in [7:0]
stall_o  output  1  freeze the pipeline at and before MEM
misalign_o  output  1  one-cycle pulse: misaligned access dropped
bus_err_o  output  1  one-cycle pulse: timeout
bus_req_o  output  1  bus request
bus_we_o  output  1  write
bus_addr_o  output  ADDR_WIDTH  word address {addr[31:2],2'b00}
bus_be_o  output  4  byte enables
bus_wdata_o  output  DATA_WIDTH  lane-shifted store data
bus_gnt_i  input  1  request accepted
bus_rvalid_i  input  1  read data valid, at least 1 cycle after gnt
bus_rdata_i  input  DATA_WIDTH  read data

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction abandons it; bus_req_o is 0 after that edge.
- Access = wmem_en_i | rmem_en_i. If both are high, the store wins.
- Byte enables:
  - B/BU: 4'b0001 << a[1:0]
  - H/HU: 4'b0011 << a[1:0]
  - W: 4'b1111
  - Other funct3: 0 and treated as misaligned.
  - Store data: mem_data_i << (8*a[1:0]).
- Misaligned: H/HU with a[0]=1, W with a[1:0]!=0, or an invalid funct3. No bus request is issued; misalign_o pulses; the block goes to RESP with rdata_o=0.
- FSM:
  - IDLE: stall_o = access (combinational). If access and aligned, latch addr/be/wdata/we into the bus registers and go to REQ.
  - REQ: bus_req_o=1, stall_o=1, bus outputs held stable. On gnt: a store goes to RESP, a load goes to WAIT_R.
  - WAIT_R: stall_o=1, bus_req_o=0. On rvalid, capture bus_rdata_i >> (8*a[1:0]) into rdata_o and go to RESP.
  - RESP: stall_o=0 and rdata_o valid. Stay in RESP while hold_i=1; otherwise go to IDLE. A new access is ignored while in RESP.
- Timeout: the counter clears on entering REQ and increments each cycle in REQ or WAIT_R. At TIMEOUT_CYCLES it pulses bus_err_o, drops bus_req_o, sets rdata_o=0 and goes to RESP.
- Best-case latency:
  - Load: 3 stall cycles (IDLE, REQ with gnt, WAIT_R with rvalid), data in the 4th cycle.
  - Store: 2 stall cycles.
- rdata_o keeps its value until the next load completes (or a misalign/timeout sets it to 0).
- rvalid outside WAIT_R and gnt outside REQ are ignored.

Decomposition:
- In buceros_header.v: funct3 size codes (`INST_BYTE, `INST_HALF_WORD, `INST_WORD, `INST_BYTE_U, `INST_HALF_WORD_U), FSM state encodings (`DMEM_IDLE/REQ/WAIT_R/RESP), `BYTE_WIDTH.
- One sub-module, dmem_lane_align: combinational be/misalign/wdata-shift/rdata-shift from funct3 and a[1:0].

Test Plan:
- LW at 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF:
  - bus_addr_o=0x100, be=1111, stall_o high 3 cycles.
  - rdata_o=0xDEADBEEF in cycle 4.
- LB at 0x103, rdata 0x80FF_0000:
  - be=1000, bus_addr_o=0x100.
  - rdata_o=0x00000080 (MEM stage then sign-extends).
- SH at 0x102, data 0x0000ABCD, gnt delayed 2 cycles:
  - be=1100, wdata=0xABCD0000.
  - bus outputs stable while waiting; stall_o drops in RESP.
- SW at 0x101:
  - No bus_req_o; misalign_o pulses 1 cycle; stall_o high only 1 cycle.
- LW with no gnt:
  - bus_err_o pulses after 15 cycles in REQ; rdata_o=0; FSM returns to IDLE.
- Load in WAIT_R, rst_n low 1 cycle:
  - IDLE next cycle, all outputs 0.
  - A later rvalid is ignored; the next LW completes normally.
